// File: rtl/comp_seq_ctrl.sv
// Serial magnitude comparator: walks two WIDTH-bit operands 2 bits per cycle, MSB slice first.
// Optional macro COMP_SEQ_EARLY_EXIT_EN ends the walk at the first differing slice.
module comp_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int STEPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       z,
  output logic [STEPW-1:0] steps
);

  localparam int S = WIDTH / 2;
  localparam logic [STEPW-1:0] LAST_IDX = STEPW'(S - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 2-bit slice compare, result encoded {eq,gt,lt}
  function automatic logic [2:0] slice_cmp(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] r;
    if (x == y) begin
      r = 3'b100;
    end else if (x > y) begin
      r = 3'b010;
    end else begin
      r = 3'b001;
    end
    return r;
  endfunction

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] sa_r, sb_r;
  logic [STEPW-1:0] idx_r;
  logic             gt_r, lt_r;
  logic             busy_r, done_r;
  logic [2:0]       z_r;
  logic [STEPW-1:0] steps_r;

  logic [2:0] slice_s;
  logic       hit_s, last_s, finish_s;
  logic       gt_nx_s, lt_nx_s;
  logic       busy_nx_s, done_nx_s;

  // Only the first differing slice decides the result; later slices are ignored.
  assign slice_s = slice_cmp(sa_r[WIDTH-1 -: 2], sb_r[WIDTH-1 -: 2]);
  assign hit_s   = ~(gt_r | lt_r) & ~slice_s[2];
  assign gt_nx_s = gt_r | (hit_s & slice_s[1]);
  assign lt_nx_s = lt_r | (hit_s & slice_s[0]);
  assign last_s  = (idx_r == LAST_IDX);

`ifdef COMP_SEQ_EARLY_EXIT_EN
  assign finish_s = last_s | hit_s;
`else
  assign finish_s = last_s;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (finish_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode, computed one cycle ahead so busy/done come straight from flops
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    case (state_nx_s)
      RUN: begin
        busy_nx_s = 1'b1;
        done_nx_s = 1'b0;
      end
      DONE: begin
        busy_nx_s = 1'b1;
        done_nx_s = 1'b1;
      end
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
  end

  // Handshake output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nx_s;
      done_r <= done_nx_s;
    end
  end

  // Operand shifters, sticky flags and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_r    <= {WIDTH{1'b0}};
      sb_r    <= {WIDTH{1'b0}};
      idx_r   <= {STEPW{1'b0}};
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
      z_r     <= 3'b000;
      steps_r <= {STEPW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            sa_r  <= a;
            sb_r  <= b;
            idx_r <= {STEPW{1'b0}};
            gt_r  <= 1'b0;
            lt_r  <= 1'b0;
          end else begin
            sa_r  <= sa_r;
            sb_r  <= sb_r;
          end
        end
        RUN: begin
          sa_r  <= sa_r << 2'd2;
          sb_r  <= sb_r << 2'd2;
          idx_r <= idx_r + STEPW'(1);
          gt_r  <= gt_nx_s;
          lt_r  <= lt_nx_s;
          if (finish_s) begin
            z_r     <= {~gt_nx_s & ~lt_nx_s, gt_nx_s, lt_nx_s};
            steps_r <= idx_r + STEPW'(1);
          end else begin
            z_r     <= z_r;
            steps_r <= steps_r;
          end
        end
        default: begin
          sa_r <= sa_r;
          sb_r <= sb_r;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign z     = z_r;
  assign steps = steps_r;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed, table-driven bench for comp_seq_ctrl (WIDTH=8, S=4); honours COMP_SEQ_EARLY_EXIT_EN.
module tb_comp_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [2:0] z;
  logic [7:0] steps;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  comp_seq_ctrl #(.WIDTH(8), .STEPW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .steps (steps)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] z;
    int         ee_steps;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int nsteps(input int ee);
`ifdef COMP_SEQ_EARLY_EXIT_EN
    return ee;
`else
    return 4 + 0 * ee;
`endif
  endfunction

  // Start at cycle 0, then watch cycles 1..12; optional ignored start pulse at cycle inj.
  task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic [2:0] ez, input int es, input int inj);
    int done_cnt, done_at, busy_bad;
    done_cnt = 0; done_at = 0; busy_bad = 0;
    a = va; b = vb; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      if (c == inj) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end else begin
        start = 1'b0; a = 8'h5A; b = 8'hC3;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (busy !== (c <= es + 1)) busy_bad++;
    end
    check({name, "_done_cycle"}, 32'(done_at), 32'(es + 1));
    check({name, "_done_count"}, 32'(done_cnt), 32'd1);
    check({name, "_busy_bad"}, 32'(busy_bad), 32'd0);
    check({name, "_z"}, 32'(z), 32'(ez));
    check({name, "_steps"}, 32'(steps), 32'(es));
  endtask

  initial begin
    int d1, d2, dcnt;
    vecs[0] = '{8'hA5, 8'hA5, 3'b100, 4};
    vecs[1] = '{8'hC0, 8'h80, 3'b010, 1};
    vecs[2] = '{8'h01, 8'h02, 3'b001, 4};
    vecs[3] = '{8'h10, 8'h0F, 3'b010, 2};
    vecs[4] = '{8'hFF, 8'hFE, 3'b010, 4};
    vecs[5] = '{8'h40, 8'h80, 3'b001, 1};
    vecs[6] = '{8'h00, 8'h00, 3'b100, 4};
    vecs[7] = '{8'h3C, 8'h3D, 3'b001, 4};
    vecs[8] = '{8'h80, 8'h7F, 3'b010, 1};

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    check("rst_steps", 32'(steps), 32'd0);
    rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].z, nsteps(vecs[i].ee_steps), 0);
    end

    // start pulsed while busy must be ignored
    run_op("busy_start", 8'h40, 8'h80, 3'b001, nsteps(1), 2);

    // reset in the middle of RUN abandons the operation
    a = 8'hA5; b = 8'hA5; start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_z", 32'(z), 32'd0);
    check("midrst_steps", 32'(steps), 32'd0);
    dcnt = 0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      if (done !== 1'b0) dcnt++;
    end
    check("midrst_no_done", 32'(dcnt), 32'd0);
    rst = 1'b0;
    next_cycle();
    run_op("after_rst", 8'h10, 8'h0F, 3'b010, nsteps(2), 0);

    // back-to-back operations, second start in the cycle after done
    d1 = 0; d2 = 0; dcnt = 0;
    a = 8'h00; b = 8'h00; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      if (c == 6) begin
        start = 1'b1; a = 8'hFF; b = 8'hFE;
        check("b2b_z1", 32'(z), 32'b100);
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        dcnt++;
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
    end
    check("b2b_done1", 32'(d1), 32'd5);
    check("b2b_done2", 32'(d2), 32'd11);
    check("b2b_count", 32'(dcnt), 32'd2);
    check("b2b_z2", 32'(z), 32'b010);
    check("b2b_steps2", 32'(steps), 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
